// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: default operand width
// and the controller state encoding.
package mult_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_step_adder.sv
// One shift-add step: conditionally adds the multiplicand magnitude to the
// WIDTH+1-bit upper accumulator and exposes the carry-out.
module mult_step_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] addend_i,
    input  logic             add_en_i,
    output logic [WIDTH:0]   sum_o,
    output logic             carry_o
);

    logic [WIDTH+1:0] addend_ext;
    logic [WIDTH+1:0] total;

    always_comb begin
        addend_ext = '0;
        if (add_en_i) begin
            addend_ext[WIDTH-1:0] = addend_i;
        end
        total   = {1'b0, acc_i} + addend_ext;
        sum_o   = total[WIDTH:0];
        carry_o = total[WIDTH+1];
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential radix-2 shift-add multiplier with valid/ready handshakes on
// both sides; signed operands are handled as magnitudes plus a sign flag.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int unsigned         CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]    LAST_STEP = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH:0]       acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic                 signed_op;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       step_sum;
    logic                 step_carry;
    logic [WIDTH:0]       acc_shift;
    logic [WIDTH-1:0]     mplier_shift;
    logic [2*WIDTH-1:0]   result_mag;

    mult_step_adder #(
        .WIDTH (WIDTH)
    ) u_step_adder (
        .acc_i    (acc_q),
        .addend_i (mcand_q),
        .add_en_i (mplier_q[0]),
        .sum_o    (step_sum),
        .carry_o  (step_carry)
    );

    // Magnitude of the most-negative value still fits in WIDTH unsigned bits.
    always_comb begin
        signed_op    = SIGNED_EN && signed_mode;
        a_mag        = (signed_op && a[WIDTH-1]) ? ('0 - a) : a;
        b_mag        = (signed_op && b[WIDTH-1]) ? ('0 - b) : b;
        acc_shift    = {step_carry, step_sum[WIDTH:1]};
        mplier_shift = {step_sum[0], mplier_q[WIDTH-1:1]};
        result_mag   = {acc_shift[WIDTH-1:0], mplier_shift};
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_shift;
                mplier_d = mplier_shift;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    product_d = neg_q ? ('0 - result_mag) : result_mag;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for the shift-add multiplier: a signed-capable 4-bit
// instance and an unsigned-only 8-bit instance driven from one sequence.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid4, in_ready4, signed_mode4, out_valid4, out_ready4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  product4;

    logic        in_valid8, in_ready8, signed_mode8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(
        .WIDTH     (4),
        .SIGNED_EN (1'b1)
    ) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid4),
        .in_ready    (in_ready4),
        .a           (a4),
        .b           (b4),
        .signed_mode (signed_mode4),
        .out_valid   (out_valid4),
        .out_ready   (out_ready4),
        .product     (product4),
        .busy        (busy4)
    );

    shift_add_multiplier #(
        .WIDTH     (8),
        .SIGNED_EN (1'b0)
    ) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid8),
        .in_ready    (in_ready8),
        .a           (a8),
        .b           (b8),
        .signed_mode (signed_mode8),
        .out_valid   (out_valid8),
        .out_ready   (out_ready8),
        .product     (product8),
        .busy        (busy8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation on the 4-bit instance, then check latency and product.
    task automatic start4(input logic [3:0] av, input logic [3:0] bv, input logic mode,
                          input string tag);
        int unsigned lat;
        in_valid4    = 1'b1;
        a4           = av;
        b4           = bv;
        signed_mode4 = mode;
        tick();
        in_valid4    = 1'b0;
        a4           = ~av;
        b4           = ~bv;
        signed_mode4 = ~mode;
        check({tag, "_busy"}, 32'(busy4), 32'd1);
        lat = 0;
        while (!out_valid4 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 32'd4);
    endtask

    task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic mode,
                        input logic [7:0] exp, input string tag);
        start4(av, bv, mode, tag);
        check({tag, "_product"}, 32'(product4), 32'(exp));
        check({tag, "_inrdy_done"}, 32'(in_ready4), 32'd0);
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        check({tag, "_inrdy_after"}, 32'(in_ready4), 32'd1);
        check({tag, "_ovalid_after"}, 32'(out_valid4), 32'd0);
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic mode,
                        input logic [15:0] exp, input string tag);
        int unsigned lat;
        in_valid8    = 1'b1;
        a8           = av;
        b8           = bv;
        signed_mode8 = mode;
        tick();
        in_valid8    = 1'b0;
        a8           = 8'h5A;
        b8           = 8'hA5;
        lat = 0;
        while (!out_valid8 && lat < 60) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 32'd8);
        check({tag, "_product"}, 32'(product8), 32'(exp));
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        check({tag, "_inrdy_after"}, 32'(in_ready8), 32'd1);
    endtask

    initial begin
        int          seen;
        int          sa, sb;
        logic [3:0]  ra4, rb4;
        logic [7:0]  ra8, rb8;
        logic        rm;
        logic [7:0]  exp4;
        logic [15:0] exp8;

        rst = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; signed_mode4 = 1'b0; out_ready4 = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; signed_mode8 = 1'b0; out_ready8 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_inrdy4",   32'(in_ready4),  32'd1);
        check("rst_ovalid4",  32'(out_valid4), 32'd0);
        check("rst_busy4",    32'(busy4),      32'd0);
        check("rst_product4", 32'(product4),   32'd0);
        check("rst_inrdy8",   32'(in_ready8),  32'd1);
        check("rst_product8", 32'(product8),   32'd0);

        run4(4'hF, 4'hF, 1'b0, 8'hE1, "u15x15");
        run4(4'hD, 4'h5, 1'b1, 8'hF1, "s_m3x5");
        run4(4'h8, 4'h8, 1'b1, 8'h40, "s_m8xm8");
        run4(4'h8, 4'h8, 1'b0, 8'h40, "u8x8");
        run4(4'h0, 4'h8, 1'b1, 8'h00, "s_0xm8");
        run4(4'hF, 4'h1, 1'b1, 8'hFF, "s_m1x1");
        run4(4'h7, 4'h8, 1'b1, 8'hC8, "s_7xm8");
        run4(4'hF, 4'h0, 1'b0, 8'h00, "u15x0");
        run4(4'h8, 4'h7, 1'b1, 8'hC8, "s_m8x7");

        // Product must hold and new requests be refused while the consumer stalls.
        start4(4'h3, 4'h3, 1'b0, "stall");
        in_valid4 = 1'b1;
        a4 = 4'h7;
        b4 = 4'h7;
        for (int i = 0; i < 10; i++) begin
            check("stall_product", 32'(product4),   32'h09);
            check("stall_ovalid",  32'(out_valid4), 32'd1);
            check("stall_inrdy",   32'(in_ready4),  32'd0);
            tick();
        end
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        check("stall_release_inrdy", 32'(in_ready4), 32'd1);
        check("stall_hold_product",  32'(product4),  32'h09);
        tick();
        check("stall_no_capture", 32'(busy4), 32'd0);

        // Abort mid-calculation.
        in_valid4 = 1'b1; a4 = 4'h5; b4 = 4'h6; signed_mode4 = 1'b0;
        tick();
        in_valid4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_inrdy",   32'(in_ready4),  32'd1);
        check("abort_ovalid",  32'(out_valid4), 32'd0);
        check("abort_busy",    32'(busy4),      32'd0);
        check("abort_product", 32'(product4),   32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid4) seen++;
            tick();
        end
        check("abort_no_stale", 32'(seen), 32'd0);

        // Reset wins over an accepting handshake in the same cycle.
        rst = 1'b1; in_valid4 = 1'b1; a4 = 4'h2; b4 = 4'h2;
        tick();
        rst = 1'b0; in_valid4 = 1'b0;
        check("rst_prio_busy", 32'(busy4), 32'd0);
        run4(4'h6, 4'h3, 1'b0, 8'h12, "post_rst");

        run8(8'hFF, 8'hFF, 1'b1, 16'hFE01, "w8_255x255");
        for (int i = 0; i < 12; i++) begin
            ra8  = 8'($urandom_range(0, 255));
            rb8  = 8'($urandom_range(0, 255));
            exp8 = 16'(int'(ra8) * int'(rb8));
            run8(ra8, rb8, 1'($urandom_range(0, 1)), exp8, "w8_rand");
        end
        for (int i = 0; i < 12; i++) begin
            ra4 = 4'($urandom_range(0, 15));
            rb4 = 4'($urandom_range(0, 15));
            rm  = 1'($urandom_range(0, 1));
            sa  = (rm && ra4[3]) ? int'(ra4) - 16 : int'(ra4);
            sb  = (rm && rb4[3]) ? int'(rb4) - 16 : int'(rb4);
            exp4 = 8'(sa * sb);
            run4(ra4, rb4, rm, exp4, "w4_rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits, legal range 2..16.
REQ-002 SHALL have parameter SIGNED_EN, default 1; 1 = signed_mode input honoured, 0 = signed_mode ignored and all operations unsigned.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operands and mode present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  multiplicand.
REQ-008 SHALL have port b  input  WIDTH  multiplier.
REQ-009 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 SHALL have port out_valid  output  1  product valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts product.
REQ-012 SHALL have port product  output  2*WIDTH  result.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 SHALL assert in_ready only in IDLE; accept on the edge where in_valid && in_ready, capture a, b and signed_mode, then go to CALC.
REQ-016 SHALL ignore a, b, signed_mode and in_valid outside the accepting edge.
REQ-017 SHALL in signed mode convert operands to magnitudes at capture and record result sign = sign(a) XOR sign(b).
REQ-018 SHALL in CALC perform one radix-2 shift-add step per edge: add the multiplicand magnitude to the WIDTH+1-bit upper accumulator when the current multiplier LSB is 1, then shift right by one.
REQ-019 SHALL complete exactly WIDTH steps and enter DONE on the WIDTH-th edge after the accepting edge; latency is fixed regardless of operand values, with no early exit on zero.
REQ-020 SHALL apply two's-complement negation to the full 2*WIDTH result on entry to DONE when the recorded sign is 1.
REQ-021 SHALL assert out_valid only in DONE, holding product stable until the edge with out_valid && out_ready, then return to IDLE.
REQ-022 SHALL drive in_ready low in DONE, including the handshake cycle; the next accept is no earlier than the cycle after returning to IDLE. Throughput is one operation per WIDTH+2 cycles minimum.
REQ-023 SHALL produce exact results over the full range, including most-negative × most-negative (e.g. WIDTH=4: -8 × -8 = +64) and any operand of 0.
REQ-024 SHALL hold product at its last value outside DONE; the value is don't-care to consumers.

Reset
REQ-025 SHALL on rst high at any edge, including mid-CALC or in DONE, go to IDLE, abort any operation without producing a result, and clear product, the accumulator, the step counter and the sign flag to 0.
REQ-026 SHALL drive in_ready=1, out_valid=0, busy=0 and product=0 in the cycle after reset.
REQ-027 SHALL give rst priority over every handshake in the same cycle.

Structure
REQ-028 SHALL take the FSM state typedef and default WIDTH constant from shared package mult_pkg.
REQ-029 SHALL instantiate one sub-module, mult_step_adder: a combinational WIDTH+1-bit conditional add with carry-out used per CALC step.
REQ-030 SHALL size the step counter as clog2(WIDTH+1) bits.

Verification
REQ-031 SHALL verify WIDTH=4, unsigned 15 × 15, out_ready=1 -> out_valid after 4 edges, product=0x00E1, in_ready back high 1 cycle later.
REQ-032 SHALL verify WIDTH=4, signed -3 (0xD) × 5 -> product=0xF1; signed -8 × -8 -> 0x0040; unsigned 0x8 × 0x8 -> 0x0040.
REQ-033 SHALL verify that with out_ready held low 10 cycles after out_valid, product and out_valid stay constant and a new in_valid pulse is not accepted (in_ready=0).
REQ-034 SHALL verify that rst asserted on the 2nd CALC edge -> next cycle IDLE, out_valid=0, product=0, and no stale result appears afterwards.
REQ-035 SHALL verify WIDTH=8, SIGNED_EN=0, 255 × 255 with signed_mode=1 -> product=0xFE01 after 8 edges; random back-to-back traffic matches a reference model.
